// File: rtl/pitt_pkg.sv
// Shared constants and helpers for the elastic pipeline register family.
package pitt_pkg;

   localparam int DEF_WIDTH      = 32;
   localparam int MAX_PIPE_DEPTH = 16;

   function automatic int CNT_W(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/rgstr_pipe_stage.sv
// One elastic stage: a valid bit plus a WIDTH-bit data register.
// Bubbles update only the valid bit, so idle cycles never toggle the data flops.
module rgstr_pipe_stage
   import pitt_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Clr,
   input  logic             Adv,
   input  logic             Vin,
   input  logic [WIDTH-1:0] N,
   output logic             Vout,
   output logic [WIDTH-1:0] Q
);

   logic             vld_q, vld_d;
   logic [WIDTH-1:0] dat_q, dat_d;
   logic             dat_en;

   // Clear empties the stage but leaves the data word untouched.
   assign dat_en = Adv & Vin & ~Clr;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      if (Clr) begin
         vld_d = 1'b0;
      end else if (Adv) begin
         vld_d = Vin;
      end
      if (dat_en) begin
         dat_d = N;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         vld_q <= 1'b0;
         dat_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
      end
   end

   assign Vout = vld_q;
   assign Q    = dat_q;

endmodule

// File: rtl/rgstr_pipe.sv
// Elastic pipeline register: DEPTH valid/ready stages with bubble compaction,
// synchronous flush and an occupancy count derived from the valid bits.
module rgstr_pipe
   import pitt_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic                        Clk,
   input  logic                        Rst,
   input  logic [WIDTH-1:0]            N,
   input  logic                        In_valid,
   output logic                        In_ready,
   output logic [WIDTH-1:0]            Q,
   output logic                        Out_valid,
   input  logic                        Out_ready,
   input  logic                        Flush,
   output logic [CNT_W(DEPTH)-1:0]     Count
);

   localparam int CW = CNT_W(DEPTH);

   if ((DEPTH < 1) || (DEPTH > MAX_PIPE_DEPTH)) begin : g_depth_chk
      $fatal(1, "rgstr_pipe: DEPTH=%0d outside 1..%0d", DEPTH, MAX_PIPE_DEPTH);
   end

   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] adv;
   logic [WIDTH-1:0] dat [DEPTH];

   // A stage may advance if it is empty or the stage downstream advances.
   always_comb begin
      logic carry;
      carry = Out_ready;
      adv   = '0;
      for (int s = DEPTH - 1; s >= 0; s--) begin
         carry  = ~vld[s] | carry;
         adv[s] = carry;
      end
   end

   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      logic             vin;
      logic [WIDTH-1:0] din;
      if (s == 0) begin : g_head
         assign vin = In_valid;
         assign din = N;
      end else begin : g_body
         assign vin = vld[s-1];
         assign din = dat[s-1];
      end

      rgstr_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .Clk  (Clk),
         .Rst  (Rst),
         .Clr  (Flush),
         .Adv  (adv[s]),
         .Vin  (vin),
         .N    (din),
         .Vout (vld[s]),
         .Q    (dat[s])
      );
   end

   always_comb begin
      Count = '0;
      for (int s = 0; s < DEPTH; s++) begin
         Count = Count + CW'(vld[s]);
      end
   end

   assign In_ready  = adv[0] & ~Flush;
   assign Out_valid = vld[DEPTH-1] & ~Flush;
   assign Q         = dat[DEPTH-1];

endmodule

// File: tb/tb_rgstr_pipe.sv
// Scoreboard bench for rgstr_pipe (WIDTH=32, DEPTH=3): directed stimulus
// queues expected output words; an independent monitor checks every transfer.
module tb_rgstr_pipe;

   localparam int WIDTH = 32;
   localparam int DEPTH = 3;

   logic             Clk = 1'b0;
   logic             Rst;
   logic [WIDTH-1:0] N;
   logic             In_valid;
   logic             In_ready;
   logic [WIDTH-1:0] Q;
   logic             Out_valid;
   logic             Out_ready;
   logic             Flush;
   logic [1:0]       Count;

   int n_cmp = 0;
   int n_err = 0;
   logic [WIDTH-1:0] exp_q [$];

   rgstr_pipe #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .N         (N),
      .In_valid  (In_valid),
      .In_ready  (In_ready),
      .Q         (Q),
      .Out_valid (Out_valid),
      .Out_ready (Out_ready),
      .Flush     (Flush),
      .Count     (Count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [WIDTH-1:0] got,
                        input logic [WIDTH-1:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h at %0t", name, got, want, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Settle combinational outputs after driving inputs for this cycle.
   task automatic settle();
      #1;
   endtask

   // Monitor: every output handshake must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge Clk);
         if (!Rst && Out_valid && Out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_out: got %0h, want no transfer at %0t", Q, $time);
            end else begin
               check("out_data", Q, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      Rst = 1'b1; N = '0; In_valid = 1'b0; Out_ready = 1'b0; Flush = 1'b0;
      tick(); tick();
      Rst = 1'b0;
      settle();
      check("rst_q", Q, 32'h0);
      check("rst_out_valid", {31'd0, Out_valid}, 32'd0);
      check("rst_count", {30'd0, Count}, 32'd0);
      check("rst_in_ready", {31'd0, In_ready}, 32'd1);

      // Streaming: three words, latency DEPTH.
      Out_ready = 1'b1;
      exp_q.push_back(32'h11); exp_q.push_back(32'h22); exp_q.push_back(32'h33);
      In_valid = 1'b1; N = 32'h11; tick();
      N = 32'h22; tick();
      N = 32'h33; settle();
      check("stream_count_c2", {30'd0, Count}, 32'd2);
      tick();
      In_valid = 1'b0; settle();
      check("stream_count_peak", {30'd0, Count}, 32'd3);
      check("stream_q_c3", Q, 32'h11);
      tick(); tick(); tick(); settle();
      check("stream_drained", {30'd0, Count}, 32'd0);

      // Backpressure: only three of five accepted until Out_ready rises.
      Out_ready = 1'b0;
      for (int i = 0; i < 5; i++) exp_q.push_back(32'hA0 + i);
      for (int i = 0; i < 3; i++) begin
         In_valid = 1'b1; N = 32'hA0 + i; settle();
         check("bp_in_ready_fill", {31'd0, In_ready}, 32'd1);
         tick();
      end
      N = 32'hA3; settle();
      check("bp_in_ready_full", {31'd0, In_ready}, 32'd0);
      check("bp_count_full", {30'd0, Count}, 32'd3);
      tick(); settle();
      check("bp_hold_q", Q, 32'hA0);
      check("bp_hold_in_ready", {31'd0, In_ready}, 32'd0);
      Out_ready = 1'b1; settle();
      check("bp_release_in_ready", {31'd0, In_ready}, 32'd1);
      tick();
      N = 32'hA4; settle();
      check("bp_q_a1", Q, 32'hA1);
      tick();
      In_valid = 1'b0; settle();
      check("bp_q_a2", Q, 32'hA2);
      tick(); settle();
      check("bp_q_a3", Q, 32'hA3);
      tick(); settle();
      check("bp_q_a4", Q, 32'hA4);
      tick(); settle();
      check("bp_drained", {30'd0, Count}, 32'd0);

      // Bubble compaction with a stalled consumer.
      Out_ready = 1'b0;
      In_valid = 1'b1; N = 32'h5; tick();
      In_valid = 1'b0; tick(); tick(); settle();
      check("bub_out_valid", {31'd0, Out_valid}, 32'd1);
      check("bub_q", Q, 32'h5);
      check("bub_count", {30'd0, Count}, 32'd1);
      check("bub_in_ready", {31'd0, In_ready}, 32'd1);
      exp_q.push_back(32'h5);
      Out_ready = 1'b1; tick();
      Out_ready = 1'b0; settle();
      check("bub_drained", {30'd0, Count}, 32'd0);

      // Flush with two words resident and a word offered.
      In_valid = 1'b1; N = 32'hB1; tick();
      N = 32'hB2; tick();
      In_valid = 1'b0; tick(); settle();
      check("fl_pre_count", {30'd0, Count}, 32'd2);
      check("fl_pre_out_valid", {31'd0, Out_valid}, 32'd1);
      Flush = 1'b1; In_valid = 1'b1; N = 32'hFF; Out_ready = 1'b1; settle();
      check("fl_in_ready", {31'd0, In_ready}, 32'd0);
      check("fl_out_valid", {31'd0, Out_valid}, 32'd0);
      tick();
      Flush = 1'b0; In_valid = 1'b0; settle();
      check("fl_count", {30'd0, Count}, 32'd0);
      check("fl_post_out_valid", {31'd0, Out_valid}, 32'd0);
      tick(); tick(); tick(); settle();
      check("fl_ff_never_seen", {30'd0, Count}, 32'd0);

      // Full pipe, simultaneous input and output transfer.
      Out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(32'hC1 + i);
         In_valid = 1'b1; N = 32'hC1 + i; tick();
      end
      exp_q.push_back(32'h77);
      N = 32'h77; Out_ready = 1'b1; settle();
      check("full_count", {30'd0, Count}, 32'd3);
      check("full_in_ready", {31'd0, In_ready}, 32'd1);
      tick();
      In_valid = 1'b0; settle();
      check("full_count_kept", {30'd0, Count}, 32'd3);
      tick(); tick(); settle();
      check("full_q_77", Q, 32'h77);
      check("full_out_valid_77", {31'd0, Out_valid}, 32'd1);
      tick(); tick(); settle();

      // Mid-stream reset discards contents.
      Out_ready = 1'b0; In_valid = 1'b1; N = 32'hD1; tick(); tick();
      In_valid = 1'b0; Rst = 1'b1; tick();
      Rst = 1'b0; settle();
      check("rst2_count", {30'd0, Count}, 32'd0);
      check("rst2_q", Q, 32'h0);

      check("sb_empty", exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
